// File: rtl/shift_register_8bit.sv
// 8-bit bidirectional shift register with synchronous parallel load and serial input.
// Outputs come straight from the state register; there is no input-to-output path.
module shift_register_8bit (
    input  logic       clock,
    input  logic       reset,
    input  logic       msb,
    input  logic [1:0] control,
    input  logic [7:0] parallel_load,
    output logic       lsb,
    output logic [7:0] parallel_read
);

    typedef enum logic [1:0] {
        OpShiftRight = 2'b00,
        OpShiftLeft  = 2'b01,
        OpLoad       = 2'b10,
        OpHold       = 2'b11
    } op_e;

    logic [7:0] q_d;
    logic [7:0] q_q;

    always_comb begin
        q_d = q_q;
        // Unknown control values fall through to hold.
        case (op_e'(control))
            OpShiftRight: q_d = {msb, q_q[7:1]};
            OpShiftLeft:  q_d = {q_q[6:0], 1'b0};
            OpLoad:       q_d = parallel_load;
            OpHold:       q_d = q_q;
            default:      q_d = q_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            q_q <= 8'h00;
        end else begin
            q_q <= q_d;
        end
    end

    assign parallel_read = q_q;
    assign lsb           = q_q[0];

endmodule

// File: tb/tb_shift_register_8bit.sv
// Scoreboard bench for shift_register_8bit: directed vectors push expected register values,
// an independent monitor pops and compares one entry after every rising edge.
module tb_shift_register_8bit;

    logic       clock;
    logic       reset;
    logic       msb;
    logic [1:0] control;
    logic [7:0] parallel_load;
    logic       lsb;
    logic [7:0] parallel_read;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];
    string      name_q[$];

    shift_register_8bit dut (
        .clock         (clock),
        .reset         (reset),
        .msb           (msb),
        .control       (control),
        .parallel_load (parallel_load),
        .lsb           (lsb),
        .parallel_read (parallel_read)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Drive one edge's inputs and record what the register must hold after that edge.
    task automatic step(input logic r, input logic [1:0] c, input logic m,
                        input logic [7:0] p, input logic [7:0] e, input string n);
        @(negedge clock);
        reset         = r;
        control       = c;
        msb           = m;
        parallel_load = p;
        exp_q.push_back(e);
        name_q.push_back(n);
    endtask

    // Monitor: every rising edge with an outstanding expectation is checked.
    initial begin
        logic [7:0] e;
        string      n;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n = name_q.pop_front();
                checks++;
                if (parallel_read !== e) begin
                    errors++;
                    $display("FAIL %s parallel_read: got %02h expected %02h", n, parallel_read, e);
                end
                checks++;
                if (lsb !== e[0]) begin
                    errors++;
                    $display("FAIL %s lsb: got %b expected %b", n, lsb, e[0]);
                end
            end
        end
    end

    initial begin
        reset         = 1'b0;
        control       = 2'b11;
        msb           = 1'b0;
        parallel_load = 8'h00;
        repeat (2) @(negedge clock);

        // Reset beats a parallel load of all ones.
        step(1'b1, 2'b10, 1'b1, 8'hFF, 8'h00, "reset_over_load");

        step(1'b0, 2'b10, 1'b0, 8'h69, 8'h69, "load_69");
        step(1'b0, 2'b00, 1'b0, 8'h00, 8'h34, "shr_msb0");
        step(1'b0, 2'b01, 1'b0, 8'h00, 8'h68, "shl_msb0");
        step(1'b0, 2'b01, 1'b1, 8'h00, 8'hD0, "shl_msb_ignored");

        step(1'b0, 2'b10, 1'b0, 8'h69, 8'h69, "reload_69");
        step(1'b0, 2'b00, 1'b1, 8'h00, 8'hB4, "shr_msb1");

        // Serial fill from zero: lsb only rises on the 8th shift.
        step(1'b1, 2'b11, 1'b0, 8'h00, 8'h00, "fill_reset");
        step(1'b0, 2'b00, 1'b1, 8'h00, 8'h80, "fill_1");
        step(1'b0, 2'b00, 1'b1, 8'h00, 8'hC0, "fill_2");
        step(1'b0, 2'b00, 1'b1, 8'h00, 8'hE0, "fill_3");
        step(1'b0, 2'b00, 1'b1, 8'h00, 8'hF0, "fill_4");
        step(1'b0, 2'b00, 1'b1, 8'h00, 8'hF8, "fill_5");
        step(1'b0, 2'b00, 1'b1, 8'h00, 8'hFC, "fill_6");
        step(1'b0, 2'b00, 1'b1, 8'h00, 8'hFE, "fill_7");
        step(1'b0, 2'b00, 1'b1, 8'h00, 8'hFF, "fill_8");

        // Hold ignores toggling msb and parallel_load.
        step(1'b0, 2'b10, 1'b0, 8'h5A, 8'h5A, "load_5a");
        step(1'b0, 2'b11, 1'b1, 8'hA5, 8'h5A, "hold_1");
        step(1'b0, 2'b11, 1'b0, 8'h3C, 8'h5A, "hold_2");
        step(1'b0, 2'b11, 1'b1, 8'hFF, 8'h5A, "hold_3");
        step(1'b1, 2'b00, 1'b1, 8'h00, 8'h00, "reset_during_shr");

        // Left-shift flush.
        step(1'b0, 2'b10, 1'b0, 8'h81, 8'h81, "load_81");
        step(1'b0, 2'b01, 1'b1, 8'h00, 8'h02, "flush_1");
        step(1'b0, 2'b01, 1'b0, 8'h00, 8'h04, "flush_2");
        step(1'b0, 2'b01, 1'b1, 8'h00, 8'h08, "flush_3");
        step(1'b0, 2'b01, 1'b0, 8'h00, 8'h10, "flush_4");
        step(1'b0, 2'b01, 1'b1, 8'h00, 8'h20, "flush_5");
        step(1'b0, 2'b01, 1'b0, 8'h00, 8'h40, "flush_6");
        step(1'b0, 2'b01, 1'b1, 8'h00, 8'h80, "flush_7");
        step(1'b0, 2'b01, 1'b0, 8'h00, 8'h00, "flush_8");

        @(negedge clock);
        control = 2'b11;
        for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(negedge clock);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
